waddr_gen: RTL and testbench

- Write-side companion of the line-buffer read address generator.
- Turns a camera pixel stream (de + pixel) into line-buffer write strobes (we/waddr/wdata).
- Publishes a committed-pixel count `head` that the reader compares against to pace its reads.
- Protects an unread line from being overwritten by holding off or dropping new lines until the reader reports finish.

---
 rtl/line_buf_pkg.sv | 19 +
 rtl/waddr_gen.sv | 155 +++++++++++++++
 tb/tb_waddr_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/line_buf_pkg.sv
// Shared line-buffer definitions: FSM state encoding, default depth, and the
// address/head width helper used by both the reader and the writer.
package line_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    DROP  = 2'd3
  } lb_state_t;

  localparam int NUM_DEFAULT = 1280;

  // Wide enough to hold NUM itself (the "line complete" head code).
  function automatic int lb_width(input int num);
    return $clog2(num + 1);
  endfunction

endpackage

// File: rtl/waddr_gen.sv
// Line-buffer writer: turns a de/pixel stream into write strobes and publishes
// a committed-pixel head count that paces the reader.
module waddr_gen
  import line_buf_pkg::*;
#(
  parameter  int NUM = NUM_DEFAULT,
  parameter  int DW  = 16,
  localparam int W   = lb_width(NUM)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          vsync,
  input  logic          de,
  input  logic [DW-1:0] pix,
  input  logic          rd_finish,
  output logic          we,
  output logic [W-1:0]  waddr,
  output logic [DW-1:0] wdata,
  output logic [W-1:0]  head,
  output logic          short_line,
  output logic          drop,
  output logic          ovf
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] LAST = W'(NUM - 1);
  localparam logic [W-1:0] FULL = W'(NUM);

  lb_state_t     state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  waddr_q, waddr_d;
  logic [W-1:0]  head_q, head_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          short_q, short_d;
  logic          drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic          arm_q, arm_d;
  logic          de_q, vs_q;

  logic de_rise, vs_rise;
  assign de_rise = de & ~de_q;
  assign vs_rise = vsync & ~vs_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      count_q <= '0;
      waddr_q <= '0;
      head_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      short_q <= 1'b0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      arm_q   <= 1'b0;
      de_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      head_q  <= head_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      short_q <= short_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      arm_q   <= arm_d;
      de_q    <= de;
      vs_q    <= vsync;
    end
  end

  // Head trails the write strobe by one cycle so it never covers the
  // address being written. arm_q blocks a line already in flight when
  // IDLE is entered (including straight out of reset).
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    arm_d   = arm_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    head_d  = we_q ? (waddr_q + ONE) : head_q;
    short_d = 1'b0;
    drop_d  = 1'b0;
    ovf_d   = ovf_q;

    if (vs_rise) begin
      state_d = IDLE;
      count_d = '0;
      head_d  = '0;
      ovf_d   = 1'b0;
      arm_d   = ~de;
    end else begin
      case (state_q)
        IDLE: begin
          head_d = '0;
          arm_d  = arm_q | ~de;
          if (de_rise && arm_q) begin
            state_d = WRITE;
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = pix;
            count_d = ONE;
          end
        end
        WRITE: begin
          if (de) begin
            we_d    = 1'b1;
            waddr_d = count_q;
            wdata_d = pix;
            count_d = count_q + ONE;
            if (count_q == LAST) state_d = DONE;
          end else begin
            state_d = DONE;
            head_d  = FULL;
            short_d = 1'b1;
          end
        end
        DONE: begin
          if (de_rise) begin
            if (rd_finish) begin
              state_d = WRITE;
              head_d  = '0;
              we_d    = 1'b1;
              waddr_d = '0;
              wdata_d = pix;
              count_d = ONE;
            end else begin
              state_d = DROP;
              drop_d  = 1'b1;
            end
          end else if (de) begin
            ovf_d = 1'b1;
          end
        end
        DROP: begin
          if (!de) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign head       = head_q;
  assign short_line = short_q;
  assign drop       = drop_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_waddr_gen.sv
// Directed, table-driven check of waddr_gen with NUM=8: each row drives one
// cycle of inputs and states the outputs expected just after that clock edge.
module tb_waddr_gen;

  localparam int NUM = 8;
  localparam int DW  = 16;
  localparam int W   = 4;

  logic          clk = 1'b0;
  logic          rstn, vsync, de, rd_finish;
  logic [DW-1:0] pix;
  logic          we, short_line, drop, ovf;
  logic [W-1:0]  waddr, head;
  logic [DW-1:0] wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  waddr_gen #(.NUM(NUM), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .vsync(vsync), .de(de), .pix(pix),
    .rd_finish(rd_finish), .we(we), .waddr(waddr), .wdata(wdata),
    .head(head), .short_line(short_line), .drop(drop), .ovf(ovf)
  );

  typedef struct {
    logic          rstn, vsync, de;
    logic [DW-1:0] pix;
    logic          rdf;
    logic          we;
    logic [W-1:0]  waddr;
    logic [DW-1:0] wdata;
    logic [W-1:0]  head;
    logic          sh, dr, ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, vs, d, input int p, input logic rf,
                              input logic e_we, input int e_wa, input int e_wd,
                              input int e_hd, input logic e_sh, e_dr, e_ov);
    vec_t v;
    v.rstn = r; v.vsync = vs; v.de = d; v.pix = DW'(p); v.rdf = rf;
    v.we = e_we; v.waddr = W'(e_wa); v.wdata = DW'(e_wd); v.head = W'(e_hd);
    v.sh = e_sh; v.dr = e_dr; v.ov = e_ov;
    return v;
  endfunction

  task automatic add(input logic r, vs, d, input int p, input logic rf,
                     input logic e_we, input int e_wa, input int e_wd,
                     input int e_hd, input logic e_sh, e_dr, e_ov);
    tbl.push_back(mk(r, vs, d, p, rf, e_we, e_wa, e_wd, e_hd, e_sh, e_dr, e_ov));
  endtask

  // Address/data are only meaningful while writing, or straight after reset.
  task automatic apply(input vec_t r, input string tag);
    logic ok;
    rstn = r.rstn; vsync = r.vsync; de = r.de; pix = r.pix; rd_finish = r.rdf;
    @(posedge clk);
    #1;
    ok = (we === r.we) && (head === r.head) && (short_line === r.sh) &&
         (drop === r.dr) && (ovf === r.ov);
    if (r.we || !r.rstn) ok = ok && (waddr === r.waddr) && (wdata === r.wdata);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got we=%0b waddr=%0d wdata=%0d head=%0d short=%0b drop=%0b ovf=%0b, want we=%0b waddr=%0d wdata=%0d head=%0d short=%0b drop=%0b ovf=%0b",
               tag, we, waddr, wdata, head, short_line, drop, ovf,
               r.we, r.waddr, r.wdata, r.head, r.sh, r.dr, r.ov);
    end else begin
      $display("ok   %s: we=%0b waddr=%0d wdata=%0d head=%0d short=%0b drop=%0b ovf=%0b",
               tag, we, waddr, wdata, head, short_line, drop, ovf);
    end
  endtask

  // Full 8-pixel written line starting at pixel value base+1, then two idle cycles.
  task automatic add_full_line(input int base, input logic rf, input logic ov);
    for (int k = 1; k <= NUM; k++) add(1, 0, 1, base + k, rf, 1, k - 1, base + k, k - 1, 0, 0, ov);
    add(1, 0, 0, 0, rf, 0, 0, 0, NUM, 0, 0, ov);
    add(1, 0, 0, 0, rf, 0, 0, 0, NUM, 0, 0, ov);
  endtask

  initial begin
    rstn = 1'b0; vsync = 1'b0; de = 1'b0; pix = '0; rd_finish = 1'b0;

    // Reset, frame start, line 1.
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_full_line(0, 0, 0);
    // Reader finished: line 2 overwrites from address 0.
    add_full_line(10, 1, 0);
    // Reader not finished: line 3 dropped, head stays at NUM.
    add(1, 0, 1, 99, 0, 0, 0, 0, NUM, 0, 1, 0);
    for (int k = 2; k <= NUM; k++) add(1, 0, 1, 99, 0, 0, 0, 0, NUM, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, NUM, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, NUM, 0, 0, 0);
    // Line 4 retried with reader finished.
    add_full_line(20, 1, 0);
    // Short line of 5 pixels: head jumps to NUM with one short_line pulse.
    for (int k = 1; k <= 5; k++) add(1, 0, 1, 30 + k, 1, 1, k - 1, 30 + k, k - 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, NUM, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, NUM, 0, 0, 0);
    // Long line of 11 pixels: 8 writes, then sticky ovf.
    for (int k = 1; k <= NUM; k++) add(1, 0, 1, 40 + k, 1, 1, k - 1, 40 + k, k - 1, 0, 0, 0);
    for (int k = 9; k <= 11; k++) add(1, 0, 1, 40 + k, 1, 0, 0, 0, NUM, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0, NUM, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0, 0, NUM, 0, 0, 1);
    // vsync rise clears ovf and head.
    add(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // vsync rise on pixel 3 while de stays high: write cancelled, rest ignored.
    apply(mk(1, 0, 1, 61, 1, 1, 0, 61, 0, 0, 0, 0), "vs_mid_p0");
    apply(mk(1, 0, 1, 62, 1, 1, 1, 62, 1, 0, 0, 0), "vs_mid_p1");
    apply(mk(1, 0, 1, 63, 1, 1, 2, 63, 2, 0, 0, 0), "vs_mid_p2");
    apply(mk(1, 1, 1, 64, 1, 0, 0, 0, 0, 0, 0, 0), "vs_mid_p3");
    for (int k = 0; k < 3; k++) apply(mk(1, 1, 1, 65 + k, 1, 0, 0, 0, 0, 0, 0, 0), "vs_mid_tail");
    apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "vs_mid_gap");

    // Reset for one cycle mid-line: de still high afterwards must be ignored.
    apply(mk(1, 0, 1, 71, 1, 1, 0, 71, 0, 0, 0, 0), "rst_mid_p0");
    apply(mk(1, 0, 1, 72, 1, 1, 1, 72, 1, 0, 0, 0), "rst_mid_p1");
    apply(mk(0, 0, 1, 73, 1, 0, 0, 0, 0, 0, 0, 0), "rst_mid_rst");
    for (int k = 0; k < 3; k++) apply(mk(1, 0, 1, 74 + k, 1, 0, 0, 0, 0, 0, 0, 0), "rst_mid_tail");
    apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "rst_mid_gap");
    apply(mk(1, 0, 1, 81, 1, 1, 0, 81, 0, 0, 0, 0), "rst_mid_new");
    apply(mk(1, 0, 1, 82, 1, 1, 1, 82, 1, 0, 0, 0), "rst_mid_new2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
